// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes, the pipeline bubble word,
// immediate format classification and opcode legality helpers.
package rv32i_pkg;

    // Base RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Bubble inserted on reset and flush: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Immediate encoding formats
    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    // Map a major opcode onto the immediate format it carries
    function automatic imm_type_e imm_type_of(input logic [6:0] opc);
        imm_type_e t;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: t = IMM_I;
            OPC_STORE:                                  t = IMM_S;
            OPC_BRANCH:                                 t = IMM_B;
            OPC_LUI, OPC_AUIPC:                         t = IMM_U;
            OPC_JAL:                                    t = IMM_J;
            default:                                    t = IMM_NONE;
        endcase
        return t;
    endfunction

    // True when the opcode is one of the eleven base RV32I major opcodes
    function automatic logic opcode_known(input logic [6:0] opc);
        logic k;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: k = 1'b1;
            default:                                              k = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32 x 32-bit integer register file: one write port, two combinational
// read ports with write-to-read bypass, x0 hardwired to zero.
module regfile_32x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] mem [32];
    logic        wr_en;

    // A write to x0 is dropped; reset also kills any write in flight so the
    // bypass path cannot leak wb_data onto the read ports during reset.
    assign wr_en = we && (waddr != 5'd0) && !rst;

    // Storage: cleared on reset, one write per rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port 1: x0 forced to zero, same-cycle write forwarded
    always_comb begin
        rdata1 = mem[raddr1];
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (wr_en && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    // Read port 2: x0 forced to zero, same-cycle write forwarded
    always_comb begin
        rdata2 = mem[raddr2];
        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (wr_en && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID pipeline register with stall/flush, field
// split, immediate generation, legality check and register file reads.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] pc_out,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        valid,
    output logic        illegal
);

    import rv32i_pkg::*;

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;
    imm_type_e   imm_sel;

    // IF/ID register: flush beats stall, stall holds, otherwise load fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (!stall) begin
            instr_q <= instr_in;
            pc_q    <= pc_in;
            valid_q <= 1'b1;
        end
    end

    // Raw instruction fields straight from the held word
    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];
    assign pc_out = pc_q;
    assign valid  = valid_q;

    // Only a real (non-bubble) instruction can be flagged; funct fields are
    // deliberately not checked, only the length bits and major opcode.
    assign illegal = valid_q && ((instr_q[1:0] != 2'b11) || !opcode_known(instr_q[6:0]));

    assign imm_sel = imm_type_of(instr_q[6:0]);

    // Immediate assembly per format, always sign-extended from instr[31]
    always_comb begin
        imm = '0;
        case (imm_sel)
            IMM_I: imm = {{20{instr_q[31]}}, instr_q[31:20]};
            IMM_S: imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            IMM_B: imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
            IMM_U: imm = {instr_q[31:12], 12'b0};
            IMM_J: imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                          instr_q[20], instr_q[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // Operand fetch; write-back runs regardless of stall and flush
    regfile_32x32 u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (instr_q[19:15]),
        .raddr2 (instr_q[24:20]),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus predicts each cycle's decode
// outputs from an instruction-level model, a monitor compares at negedge.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] pc_out;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        valid;
    logic        illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk      (clk),
        .rst      (rst),
        .pc_in    (pc_in),
        .instr_in (instr_in),
        .stall    (stall),
        .flush    (flush),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .pc_out   (pc_out),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .valid    (valid),
        .illegal  (illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic        valid;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   vector_count = 0;
    int   miss_count = 0;

    // Instruction-level model state
    logic [31:0] m_instr = 32'h0000_0013;
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_regs [32];
    logic [6:0]  legal_ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                   7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                   7'b0110011, 7'b0001111, 7'b1110011};

    function automatic logic is_legal(input logic [31:0] w);
        for (int i = 0; i < 11; i++) begin
            if (w[6:0] == legal_ops[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Immediate as a signed offset built by arithmetic on bit groups
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int v;
        v = 0;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                v = (w[31] ? -2048 : 0) + int'(w[30:20]);
            7'b0100011:
                v = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
            7'b1100011:
                v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                    + int'(w[11:8]) * 2;
            7'b0110111, 7'b0010111:
                v = int'(w[31:12]) * 4096;
            7'b1101111:
                v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                    + int'(w[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (we && wrd == idx) return wd;
        return m_regs[idx];
    endfunction

    // Drive one cycle of inputs just after the edge, predict this cycle's
    // outputs, then advance the model as the coming edge will
    task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic [31:0] pcv,
                                 input logic st, input logic fl, input logic we,
                                 input logic [4:0] wrd, input logic [31:0] wd);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; instr_in = ins; pc_in = pcv; stall = st; flush = fl;
        wb_we = we; wb_rd = wrd; wb_data = wd;
        if (r) begin
            m_instr = 32'h0000_0013; m_pc = '0; m_valid = 1'b0;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end
        e.pc       = m_pc;
        e.instr    = m_instr;
        e.imm      = ref_imm(m_instr);
        e.rs1_data = ref_read(m_instr[19:15], we && !r, wrd, wd);
        e.rs2_data = ref_read(m_instr[24:20], we && !r, wrd, wd);
        e.valid    = m_valid;
        e.illegal  = m_valid && !is_legal(m_instr);
        sb.push_back(e);
        if (!r) begin
            if (we && wrd != 5'd0) m_regs[wrd] = wd;
            if (fl) begin
                m_instr = 32'h0000_0013; m_pc = '0; m_valid = 1'b0;
            end else if (!st) begin
                m_instr = ins; m_pc = pcv; m_valid = 1'b1;
            end
        end
    endtask

    task automatic compare_field(input string name, input logic [31:0] act, input logic [31:0] exp);
        vector_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compare_field("pc_out",   pc_out,                 e.pc);
        compare_field("opcode",   {25'b0, opcode},        {25'b0, e.instr[6:0]});
        compare_field("rd",       {27'b0, rd},            {27'b0, e.instr[11:7]});
        compare_field("funct3",   {29'b0, funct3},        {29'b0, e.instr[14:12]});
        compare_field("rs1",      {27'b0, rs1},           {27'b0, e.instr[19:15]});
        compare_field("rs2",      {27'b0, rs2},           {27'b0, e.instr[24:20]});
        compare_field("funct7",   {25'b0, funct7},        {25'b0, e.instr[31:25]});
        compare_field("imm",      imm,                    e.imm);
        compare_field("rs1_data", rs1_data,               e.rs1_data);
        compare_field("rs2_data", rs2_data,               e.rs2_data);
        compare_field("valid",    {31'b0, valid},         {31'b0, e.valid});
        compare_field("illegal",  {31'b0, illegal},       {31'b0, e.illegal});
    endtask

    // Monitor: every negedge with a pending prediction is checked
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) < 6) w[6:0] = legal_ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 1) begin
            w[17:15] = 3'($urandom_range(0, 7)); w[19:18] = 2'b00;
            w[22:20] = 3'($urandom_range(0, 7)); w[24:23] = 2'b00;
        end
        return w;
    endfunction

    // Directed cases followed by randomized traffic
    initial begin
        int drain;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;

        applyStimulus(1, 32'h0000_0000, 32'h0,  0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'hFFF0_8093, 32'h10, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'hFE00_0EE3, 32'h14, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h0080_00EF, 32'h18, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h0002_8013, 32'h1C, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h0000_0013, 32'h20, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h0000_0013, 32'h24, 1, 0, 1, 5'd5, 32'hDEAD_BEEF);
        applyStimulus(0, 32'h0000_0013, 32'h24, 1, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h0000_0013, 32'h24, 0, 0, 1, 5'd0, 32'h1234);
        applyStimulus(0, 32'h00A0_0093, 32'h28, 0, 0, 1, 5'd0, 32'h1234);
        applyStimulus(0, 32'h1111_1113, 32'h2C, 1, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h2222_2223, 32'h30, 1, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h3333_3333, 32'h34, 1, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h4444_4443, 32'h38, 1, 1, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h0000_0000, 32'h3C, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h0000_0000, 32'h40, 0, 1, 0, 5'd0, 32'h0);
        applyStimulus(0, 32'h0000_0000, 32'h44, 0, 0, 0, 5'd0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            applyStimulus((n == 200) || ($urandom_range(0, 79) == 0),
                          rand_instr(), $urandom,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom),
                          $urandom);
        end
        applyStimulus(0, 32'h0000_0013, 32'h0, 1, 0, 0, 5'd0, 32'h0);

        drain = 0;
        while (sb.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        if (sb.size() > 0) begin
            miss_count++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I decode stage placed directly downstream of the fetch stage; it consumes the fetched PC and instruction word. It holds them in an IF/ID pipeline register with stall and flush control, and splits the instruction into fields. It generates the sign-extended immediate and reads two operands from an integrated 32×32 register file with a write-back port. Its outputs feed the execute stage one cycle after fetch presents an instruction.

## Interface
- `NOP_INSTR`, default 32'h0000_0013; instruction loaded on reset/flush (`addi x0,x0,0`).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_in`  in  32  PC of the fetched instruction, from fetch.
- `instr_in`  in  32  fetched instruction word.
- `stall`  in  1  hold IF/ID register contents.
- `flush`  in  1  replace IF/ID contents with `NOP_INSTR`, `valid`=0.
- `wb_we`  in  1  register-file write enable.
- `wb_rd`  in  5  write-back destination index.
- `wb_data`  in  32  write-back value.
- `pc_out`  out  32  registered PC.
- `opcode`  out  7, `funct3`  out  3, `funct7`  out  7, `rd`/`rs1`/`rs2`  out  5 each: instruction fields.
- `imm`  out  32  sign-extended immediate.
- `rs1_data`, `rs2_data`  out  32  operand values.
- `valid`  out  1  IF/ID holds a real instruction.
- `illegal`  out  1  `valid` and the instruction is not RV32I-encodable.

## Operation
- IF/ID register, per rising edge, in priority order: `flush` → instr=`NOP_INSTR`, pc=0, valid=0. Else `stall` → hold all. Else → load `instr_in`, `pc_in`, valid=1.
- Flush wins over simultaneous stall.
- Fields come straight from registered instr: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- Immediate, selected by opcode, always sign-extended from instr[31]:
  - I (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011): instr[31:20].
  - S (0100011): {instr[31:25], instr[11:7]}.
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (LUI 0110111, AUIPC 0010111): {instr[31:12], 12'b0}.
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - OP 0110011, FENCE 0001111, anything else: 0.
- `illegal` = valid and (instr[1:0]≠2'b11 or opcode outside the 11 listed opcodes). Funct fields are not checked.
- Register file: x0 reads 0 always. A write occurs on the edge when `wb_we` and `wb_rd`≠0; writes to x0 are dropped.
- Read bypass: if `wb_we`, `wb_rd`≠0, and `wb_rd`==rsN, then `rsN_data`=`wb_data` in the same cycle.
- Write-back is independent of stall/flush; flushes never block writes.

## Timing
- Latency: `instr_in`/`pc_in` sampled at edge N appear decoded after edge N, valid throughout cycle N+1. All decode outputs are combinational from the IF/ID register and register file.
- Reset, asynchronous, immediate on assertion:
  - instr=`NOP_INSTR`, pc_out=0, valid=0, illegal=0.
  - Decoded NOP fields: opcode=0010011, rd=rs1=0, imm=0.
  - All 32 registers = 0, so rs1_data=rs2_data=0.
- Reset mid-stall or mid-write discards the pending write and the held instruction.
- Deassertion is synchronous to `clk` externally. The first load occurs on the first edge with `rst`=0.

## Structure
- Shared package `rv32i_pkg`:
  - opcode localparams (OPC_LUI … OPC_SYSTEM);
  - `NOP_INSTR` constant;
  - `imm_type_e` enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- Sub-module `regfile_32x32`: async reset, one write port, two combinational read ports with bypass, x0 forced zero.
- Immediate generation and IF/ID register stay in `decode_stage`.

## Test plan
- Reset: assert `rst` mid-cycle → outputs go to reset values immediately; valid=0, rs1_data=0.
- instr_in=32'hFFF0_8093 (addi x1,x1,-1), pc_in=32'h10 → next cycle: opcode=0010011, rd=1, rs1=1, imm=32'hFFFF_FFFF, pc_out=32'h10, valid=1.
- Branch 32'hFE00_0EE3 (beq x0,x0,-4) → imm=32'hFFFF_FFFC. Then jal 32'h0080_00EF → imm=8, rd=1.
- Write-back bypass and x0: wb_we=1, wb_rd=5, wb_data=32'hDEAD_BEEF with decoded rs1=5 → rs1_data=DEADBEEF the same cycle, held afterwards. Write to x0 with 32'h1234 → reading x0 returns 0.
- Stall and flush: hold stall=1 over 3 new instr_in → outputs unchanged. Assert stall=1 and flush=1 together → NOP, valid=0.
- instr_in=32'h0000_0000 → illegal=1. Same word after flush → illegal=0 (valid=0).
